pal_prog: RTL and testbench



---
 rtl/pal_prog.sv | 154 +++++++++++++++
 tb/tb_pal_prog.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pal_prog.sv
// pal_prog: run-time programmable sum-of-products array with a 2-stage
// valid/ready pipeline. Product terms (AND plane + OR plane) are written one
// at a time through the cfg port. Define PAL_POL_EN to add a per-output
// polarity register (cfg_pol_we/cfg_pol) that is XORed into the result.
module pal_prog #(
    parameter int IW = 4,
    parameter int OW = 4,
    parameter int PT = 8,
    parameter int AW = $clog2(PT)
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IW-1:0]   in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OW-1:0]   out_data,
    input  logic            cfg_we,
    input  logic [AW-1:0]   cfg_addr,
    input  logic [2*IW-1:0] cfg_and,
`ifdef PAL_POL_EN
    input  logic [OW-1:0]   cfg_or,
    input  logic            cfg_pol_we,
    input  logic [OW-1:0]   cfg_pol
`else
    input  logic [OW-1:0]   cfg_or
`endif
);

    // Plane storage: and_q[t][IW-1:0] = true literals, [2IW-1:IW] = complemented
    logic [PT-1:0][2*IW-1:0] and_q, and_d;
    logic [PT-1:0][OW-1:0]   or_q, or_d;

    // Pipeline state
    logic          s1_valid_q, s1_valid_d;
    logic [OW-1:0] s1_raw_q, s1_raw_d;
    logic          out_valid_q, out_valid_d;
    logic [OW-1:0] out_data_q, out_data_d;

    logic          s2_free, in_fire, s1_move;
    logic [PT-1:0] hit;
    logic [OW-1:0] raw_sop;
    logic [OW-1:0] s1_result;

`ifdef PAL_POL_EN
    logic [OW-1:0] pol_q, pol_d;
    logic [OW-1:0] s1_pol_q, s1_pol_d;

    // Polarity register write
    always_comb begin
        pol_d = pol_q;
        if (cfg_pol_we) pol_d = cfg_pol;
    end

    assign s1_result = s1_raw_q ^ s1_pol_q;
`else
    assign s1_result = s1_raw_q;
`endif

    // Plane write; out-of-range term indices are dropped
    always_comb begin
        and_d = and_q;
        or_d  = or_q;
        if (cfg_we && (int'(cfg_addr) < PT)) begin
            and_d[cfg_addr] = cfg_and;
            or_d[cfg_addr]  = cfg_or;
        end
    end

    // An empty AND mask disables the term; a true+complement pair on the
    // same input can never be satisfied, so it falls out of the same test.
    for (genvar t = 0; t < PT; t++) begin : g_term
        assign hit[t] = (|and_q[t])
                     && ((and_q[t][IW-1:0] & ~in_data) == '0)
                     && ((and_q[t][2*IW-1:IW] & in_data) == '0);
    end

    // OR plane: collect outputs of every hitting term
    always_comb begin
        raw_sop = '0;
        for (int t = 0; t < PT; t++) begin
            if (hit[t]) raw_sop = raw_sop | or_q[t];
        end
    end

    // Handshake: in_ready depends on out_ready but never on in_valid
    assign s2_free  = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_free;
    assign in_fire  = in_valid && in_ready;
    assign s1_move  = s1_valid_q && s2_free;

    // Stage 1 captures the SOP from the planes as they are before any
    // same-cycle cfg write, which gives the snapshot-at-accept behaviour.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_raw_d   = s1_raw_q;
`ifdef PAL_POL_EN
        s1_pol_d   = s1_pol_q;
`endif
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_raw_d   = raw_sop;
`ifdef PAL_POL_EN
            s1_pol_d   = pol_q;
`endif
        end else if (s1_move) begin
            s1_valid_d = 1'b0;
        end
    end

    // Stage 2 holds the result stable until the consumer takes it
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (s1_move) begin
            out_valid_d = 1'b1;
            out_data_d  = s1_result;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            and_q       <= '0;
            or_q        <= '0;
            s1_valid_q  <= 1'b0;
            s1_raw_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
`ifdef PAL_POL_EN
            pol_q       <= '0;
            s1_pol_q    <= '0;
`endif
        end else begin
            and_q       <= and_d;
            or_q        <= or_d;
            s1_valid_q  <= s1_valid_d;
            s1_raw_q    <= s1_raw_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
`ifdef PAL_POL_EN
            pol_q       <= pol_d;
            s1_pol_q    <= s1_pol_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_pal_prog.sv
// Bench for pal_prog: directed test-plan steps followed by random traffic,
// checked against a behavioural model (term list + FIFO of pending results).
module tb_pal_prog;
    localparam int IW = 4;
    localparam int OW = 4;
    localparam int PT = 8;
    localparam int AW = $clog2(PT);

    logic            clk = 1'b0;
    logic            rst_b = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [IW-1:0]   in_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [OW-1:0]   out_data;
    logic            cfg_we = 1'b0;
    logic [AW-1:0]   cfg_addr = '0;
    logic [2*IW-1:0] cfg_and = '0;
    logic [OW-1:0]   cfg_or = '0;
`ifdef PAL_POL_EN
    logic            cfg_pol_we = 1'b0;
    logic [OW-1:0]   cfg_pol = '0;
`endif

    pal_prog #(.IW(IW), .OW(OW), .PT(PT)) dut (
        .clk(clk), .rst_b(rst_b),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_and(cfg_and),
`ifdef PAL_POL_EN
        .cfg_or(cfg_or), .cfg_pol_we(cfg_pol_we), .cfg_pol(cfg_pol)
`else
        .cfg_or(cfg_or)
`endif
    );

    always #5 clk = ~clk;

    // Reference model
    typedef struct {
        logic [OW-1:0] v;
        int            t;   // first cycle in which the word may be shown
    } ent_t;

    logic [2*IW-1:0] m_and [PT];
    logic [OW-1:0]   m_or  [PT];
    logic [OW-1:0]   m_pol;
    ent_t            q[$];
    logic [OW-1:0]   got[$];
    int              cyc = 0;
    int              total = 0;
    int              bad = 0;

    function automatic logic [OW-1:0] model_eval(input logic [IW-1:0] d);
        logic [OW-1:0] r;
        bit any, ok;
        r = '0;
        for (int t = 0; t < PT; t++) begin
            any = 0;
            ok  = 1;
            for (int j = 0; j < IW; j++) begin
                if (m_and[t][j])      begin any = 1; if (!d[j]) ok = 0; end
                if (m_and[t][IW + j]) begin any = 1; if (d[j])  ok = 0; end
            end
            if (any && ok) r = r | m_or[t];
        end
        return r ^ m_pol;
    endfunction

    task automatic model_clear();
        for (int t = 0; t < PT; t++) begin
            m_and[t] = '0;
            m_or[t]  = '0;
        end
        m_pol = '0;
        q.delete();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check just after, update model at posedge
    task automatic step(input logic iv, input logic [IW-1:0] d, input logic ordy,
                        input logic we, input logic [AW-1:0] a,
                        input logic [2*IW-1:0] am, input logic [OW-1:0] om,
                        input logic pwe, input logic [OW-1:0] pv);
        logic exp_rdy, exp_ov, acc, pop;
        logic [OW-1:0] seen;
        @(negedge clk);
        in_valid = iv; in_data = d; out_ready = ordy;
        cfg_we = we; cfg_addr = a; cfg_and = am; cfg_or = om;
`ifdef PAL_POL_EN
        cfg_pol_we = pwe; cfg_pol = pv;
`endif
        #1;
        exp_rdy = (q.size() < 2) || ordy;
        exp_ov  = (q.size() > 0) && (q[0].t <= cyc);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        if (exp_ov) chk("out_data", 32'(out_data), 32'(q[0].v));
        seen = out_data;
        acc = iv && exp_rdy;
        pop = exp_ov && ordy;
        @(posedge clk);
        cyc++;
        if (pop) begin
            got.push_back(seen);
            void'(q.pop_front());
        end
        if (acc) q.push_back('{v: model_eval(d), t: cyc + 1});
        if (we && (int'(a) < PT)) begin
            m_and[a] = am;
            m_or[a]  = om;
        end
`ifdef PAL_POL_EN
        if (pwe) m_pol = pv;
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 1, 0, '0, '0, '0, 0, '0);
    endtask

    task automatic send(input logic [IW-1:0] d);
        step(1, d, 1, 0, '0, '0, '0, 0, '0);
    endtask

    task automatic cfg(input logic [AW-1:0] a, input logic [2*IW-1:0] am, input logic [OW-1:0] om);
        step(0, '0, 1, 1, a, am, om, 0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 0; cfg_we = 0; out_ready = 1;
`ifdef PAL_POL_EN
        cfg_pol_we = 0;
`endif
        #2 rst_b = 0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        model_clear();
        @(negedge clk);
        rst_b = 1;
    endtask

    initial begin
        int base;
        model_clear();
        do_reset();

        // Unprogrammed array: everything maps to 0
        base = got.size();
        send(4'b0000); send(4'b1111); send(4'b1010);
        idle(3);
        chk("unprog0", 32'(got[base]),   32'h0);
        chk("unprog1", 32'(got[base+1]), 32'h0);
        chk("unprog2", 32'(got[base+2]), 32'h0);

        // Term 0: i0&i1 -> 0011; term 1: i2&~i3 -> 0100
        cfg(0, 8'b0000_0011, 4'b0011);
        cfg(1, 8'b1000_0100, 4'b0100);
        base = got.size();
        send(4'b0011); send(4'b0111); send(4'b1100);
        idle(3);
        chk("sop0", 32'(got[base]),   32'h3);
        chk("sop1", 32'(got[base+1]), 32'h7);
        chk("sop2", 32'(got[base+2]), 32'h0);

        // Backpressure: two accepts fill the pipe, third waits
        base = got.size();
        step(1, 4'b0011, 0, 0, '0, '0, '0, 0, '0);
        step(1, 4'b0111, 0, 0, '0, '0, '0, 0, '0);
        step(1, 4'b1111, 0, 0, '0, '0, '0, 0, '0);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_hold", 32'(out_data), 32'h3);
        step(1, 4'b1111, 1, 0, '0, '0, '0, 0, '0);
        idle(3);
        chk("bp0", 32'(got[base]),   32'h3);
        chk("bp1", 32'(got[base+1]), 32'h7);
        chk("bp2", 32'(got[base+2]), 32'h3);

        // Snapshot: same-cycle rewrite of term 0 is not seen by that word
        base = got.size();
        step(1, 4'b0011, 1, 1, 0, 8'b0000_0011, 4'b1000, 0, '0);
        send(4'b0011);
        idle(3);
        chk("snap_old", 32'(got[base]),   32'h3);
        chk("snap_new", 32'(got[base+1]), 32'h8);

        // Disabled and contradictory terms never contribute
        cfg(2, 8'b0000_0000, 4'b1111);
        cfg(3, 8'b0001_0001, 4'b1111);
        base = got.size();
        send(4'b0011); send(4'b0111); send(4'b0000); send(4'b1111); send(4'b1110);
        idle(3);
        chk("dis0", 32'(got[base]),   32'h8);
        chk("dis1", 32'(got[base+1]), 32'hC);
        chk("dis2", 32'(got[base+2]), 32'h0);
        chk("dis3", 32'(got[base+3]), 32'h8);
        chk("dis4", 32'(got[base+4]), 32'h0);

`ifdef PAL_POL_EN
        step(0, '0, 1, 0, '0, '0, '0, 1, 4'b1001);
        base = got.size();
        send(4'b1100);
        idle(3);
        chk("pol", 32'(got[base]), 32'h9);
`endif

        // Reset with a word in flight: it is discarded, planes cleared
        send(4'b0011);
        do_reset();
        idle(2);
        base = got.size();
        send(4'b0011);
        idle(3);
        chk("post_rst", 32'(got[base]), 32'h0);

        // Random traffic with occasional reprogramming
        for (int i = 0; i < 600; i++) begin
            logic we, pwe;
            we  = ($urandom_range(0, 7) == 0);
            pwe = ($urandom_range(0, 15) == 0);
            step($urandom_range(0, 3) != 0, IW'($urandom), $urandom_range(0, 3) != 0,
                 we, AW'($urandom), (2*IW)'($urandom & $urandom), OW'($urandom),
                 pwe, OW'($urandom));
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
